// File: rtl/pulse_seq_ctrl.sv
// One-hot phase sequencer: walks a single pulse from MSB to LSB with a
// programmable per-phase dwell, in one-shot or continuous mode, with pause/stop.
module pulse_seq_ctrl #(
  parameter int N_PHASE = 6,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_PHASE-1:0] phase_out,
  output logic [2:0]         phase_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]         LAST_IDX  = 3'(N_PHASE - 1);
  localparam logic [N_PHASE-1:0] FIRST_HOT = {1'b1, {(N_PHASE-1){1'b0}}};

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_r, dwell_d;
  logic                 mode_r, mode_d;
  logic [N_PHASE-1:0]   phase_d;
  logic [2:0]           idx_d;
  logic                 busy_d, done_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dwell_r   <= '0;
      mode_r    <= 1'b0;
      phase_out <= '0;
      phase_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dwell_r   <= dwell_d;
      mode_r    <= mode_d;
      phase_out <= phase_d;
      phase_idx <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_r;
    mode_d  = mode_r;
    phase_d = phase_out;
    idx_d   = phase_idx;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          mode_d  = mode;
          dwell_d = dwell;
          cnt_d   = '0;
          phase_d = FIRST_HOT;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          phase_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (pause) begin
          // Frozen cycle: phase and count hold, so the run is stretched by
          // exactly the number of cycles pause stays high.
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (cnt_q == dwell_r) begin
            cnt_d = '0;
            if (phase_idx == LAST_IDX) begin
              if (mode_r) begin
                phase_d = FIRST_HOT;
                idx_d   = '0;
              end else begin
                state_d = ST_DONE;
                phase_d = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              phase_d = phase_out >> 1;
              idx_d   = phase_idx + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        phase_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: expected per-cycle outputs are queued
// as stimulus is driven and compared one per clock after each rising edge.
module tb_pulse_seq_ctrl;

  localparam int N_PHASE = 6;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, pause, mode;
  logic [DWELL_W-1:0] dwell;
  logic [N_PHASE-1:0] phase_out;
  logic [2:0]         phase_idx;
  logic               busy, done;

  // Packed expectation: {phase_out, phase_idx, busy, done}
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  string       cur_tag;
  int          step_no;

  pulse_seq_ctrl #(.N_PHASE(N_PHASE), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .dwell     (dwell),
    .phase_out (phase_out),
    .phase_idx (phase_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (phase_out,idx,busy,done)", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {phase_out, phase_idx, busy, done};
  endfunction

  task automatic push_phase(input int p, input int hold);
    logic [N_PHASE-1:0] hot;
    hot = {1'b1, {(N_PHASE-1){1'b0}}};
    hot = hot >> p;
    for (int i = 0; i < hold; i++) exp_q.push_back({hot, 3'(p), 1'b1, 1'b0});
  endtask

  task automatic push_done();
    exp_q.push_back({{N_PHASE{1'b0}}, 3'd0, 1'b0, 1'b1});
  endtask

  task automatic push_idle();
    exp_q.push_back('0);
  endtask

  task automatic step();
    logic [10:0] e;
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      check($sformatf("%s_noexp%0d", cur_tag, step_no), 32'(obs()), 32'h7ff);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", cur_tag, step_no), 32'(obs()), 32'(e));
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
  endtask

  task automatic new_test(input string tag);
    cur_tag = tag;
    step_no = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; dwell = '0;
    #22;
    check("reset_outputs", 32'(obs()), 32'h0);
    rst_n = 1'b1;
    step_n(0);
    @(posedge clk); #1;

    // One-shot, dwell=2; mode/dwell changes and start mid-run are ignored,
    // start in the DONE cycle is ignored too.
    new_test("oneshot");
    mode = 1'b0; dwell = 8'd2; start = 1'b1;
    for (int p = 0; p < N_PHASE; p++) push_phase(p, 3);
    push_done();
    push_idle();
    push_idle();
    step();
    start = 1'b0; mode = 1'b1; dwell = 8'd7;
    step_n(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(12);          // 18 busy cycles consumed
    step();              // DONE visible
    start = 1'b1;        // sampled while in DONE: must be ignored
    step();
    start = 1'b0;
    step();

    // Continuous, dwell=0: walks and wraps with no gap, then stop (with pause)
    // in phase 4 returns to IDLE without done.
    new_test("contin");
    mode = 1'b1; dwell = 8'd0; start = 1'b1;
    for (int i = 0; i < 23; i++) push_phase(i % N_PHASE, 1);
    step();
    start = 1'b0;
    step_n(22);
    stop = 1'b1; pause = 1'b1;
    push_idle();
    step();
    stop = 1'b0; pause = 1'b0;
    push_idle();
    step();

    // start together with stop in IDLE is rejected.
    new_test("startstop");
    start = 1'b1; stop = 1'b1; mode = 1'b0; dwell = 8'd1;
    push_idle();
    step();
    start = 1'b0; stop = 1'b0;
    push_idle();
    step();

    // One-shot dwell=3 with pause high for 5 cycles during phase 2.
    new_test("pause");
    mode = 1'b0; dwell = 8'd3; start = 1'b1;
    push_phase(0, 4);
    push_phase(1, 4);
    push_phase(2, 9);
    for (int p = 3; p < N_PHASE; p++) push_phase(p, 4);
    push_done();
    push_idle();
    step();
    start = 1'b0;
    step_n(9);           // through phase 2, count 1
    pause = 1'b1;
    step_n(5);
    pause = 1'b0;
    drain();

    // Asynchronous reset during phase 3, then a fresh start with dwell=0.
    new_test("reset_mid");
    mode = 1'b0; dwell = 8'd1; start = 1'b1;
    for (int p = 0; p < N_PHASE; p++) push_phase(p, 2);
    step();
    start = 1'b0;
    step_n(6);           // phase 3 visible
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", 32'(obs()), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_idle();
    step();
    new_test("after_reset");
    mode = 1'b0; dwell = 8'd0; start = 1'b1;
    for (int p = 0; p < N_PHASE; p++) push_phase(p, 1);
    push_done();
    push_idle();
    step();
    start = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
